gray_counter: RTL

- Parametrised, registered successor to the team's 4-bit combinational binary-to-Gray converter.
- Holds a WIDTH-bit count that steps up or down on enable, and presents it as both a binary and a Gray-coded value.
- Supports synchronous load of either a binary or a Gray-coded value, and flags wrap-around.
- Intended for async-FIFO pointers and position encoders elsewhere in the design.

---
 rtl/gray_counter_pkg.sv | 11 +
 rtl/gray_counter_gray2bin.sv | 19 +
 rtl/gray_counter.sv | 68 ++++++
 3 files changed

// File: rtl/gray_counter_pkg.sv
// Shared definitions for the Gray-code counter family: default width and
// the binary-to-Gray mapping used on the counting path.
package gray_counter_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_gray2bin.sv
// Width-generic Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above its position (prefix XOR from the MSB down).
import gray_counter_pkg::*;

module gray2bin #(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter presenting its count in both binary and Gray
// code, with binary or Gray-coded synchronous load and a wrap-around pulse.
import gray_counter_pkg::*;

module gray_counter #(
  parameter int          WIDTH   = GRAY_W_DEFAULT,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             parity
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RST_BIN)));
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  gray2bin #(.WIDTH(WIDTH)) u_load_dec (
    .gray (load_val),
    .bin  (load_bin)
  );

  // Gray is derived from the next binary value so both registers always agree
  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      if (up) begin
        bin_next  = bin + ONE;
        wrap_next = &bin;
      end else begin
        bin_next  = bin - ONE;
        wrap_next = ~|bin;
      end
    end
    gray_next = WIDTH'(bin2gray(32'(bin_next)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin    <= RST_BIN;
      gray   <= RST_GRAY;
      wrap   <= 1'b0;
      parity <= ^RST_GRAY;
    end else begin
      bin    <= bin_next;
      gray   <= gray_next;
      wrap   <= wrap_next;
      parity <= ^gray_next;
    end
  end

endmodule
